// File: rtl/note_recorder_pkg.sv
// Shared types and constants for the note recorder: FSM encoding, entry layout
// {notes[7:0], octave[1:0], dur[7:0]} and parameter defaults.
package note_recorder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

  localparam int NOTES_W = 8;
  localparam int OCT_W   = 2;
  localparam int DUR_W   = 8;
  localparam int ENTRY_W = 18;

  localparam int DUR_LSB   = 0;
  localparam int OCT_LSB   = DUR_LSB + DUR_W;
  localparam int NOTES_LSB = OCT_LSB + OCT_W;

  localparam int TICK_DIV_DEF = 1000000;
  localparam int DEPTH_DEF    = 64;

  localparam logic [DUR_W-1:0] DUR_MAX = '1;

endpackage

// File: rtl/note_recorder_note_mem.sv
// Simple dual-port event store: one write port, one registered read port, no reset.
// Read data appears one cycle after the address; no backpressure.
module note_mem #(
  parameter int DEPTH = 64,
  parameter int W     = 18,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/note_recorder.sv
// Records timed note/octave events into a small RAM and replays them to the buzzer.
// Replay output lags the read pointer by 2 cycles; commands are single-cycle pulses, never stalled.
module note_recorder
  import note_recorder_pkg::*;
#(
  parameter int  TICK_DIV = TICK_DIV_DEF,
  parameter int  DEPTH    = DEPTH_DEF,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    notes_in,
  input  logic [1:0]    octave_in,
  input  logic          rec_start,
  input  logic          rec_stop,
  input  logic          play_start,
  input  logic          play_stop,
  output logic [7:0]    notes_out,
  output logic [1:0]    octave_out,
  output logic          recording,
  output logic          playing,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int TW  = $clog2(TICK_DIV);
  localparam int CUR_W = NOTES_W + OCT_W;

  state_e               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q, full_d;
  logic [CUR_W-1:0]     cur_q, cur_d;
  logic [DUR_W-1:0]     dur_q, dur_d;
  logic [CW-1:0]        rd_q, rd_d;
  logic [DUR_W-1:0]     elapsed_q, elapsed_d;
  logic                 vld1_q, vld1_d;
  logic [NOTES_W-1:0]   notes_out_q, notes_out_d;
  logic [OCT_W-1:0]     octave_out_q, octave_out_d;
  logic                 recording_q, playing_q;

  logic                 tick, tick_clr, we;
  logic [CUR_W-1:0]     live;
  logic [CW-1:0]        count_inc;
  logic                 last_slot;
  logic [ENTRY_W-1:0]   rdata;
  logic [DUR_W-1:0]     rd_dur;

  assign live      = {notes_in, octave_in};
  assign tick      = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign count_inc = count_q + CW'(1);
  assign last_slot = (count_inc == CW'(DEPTH));
  assign rd_dur    = rdata[DUR_LSB +: DUR_W];

  note_mem #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i ({cur_q, dur_q}),
    .raddr_i (rd_q[AW-1:0]),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    full_d    = full_q;
    cur_d     = cur_q;
    dur_d     = dur_q;
    rd_d      = rd_q;
    elapsed_d = elapsed_q;
    tick_clr  = 1'b0;
    we        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rec_start) begin
          state_d  = ST_REC;
          count_d  = '0;
          full_d   = 1'b0;
          cur_d    = live;
          dur_d    = '0;
          tick_clr = 1'b1;
        end else if (play_start && count_q != '0) begin
          state_d   = ST_PLAY;
          rd_d      = '0;
          elapsed_d = '0;
          tick_clr  = 1'b1;
        end
      end
      ST_REC: begin
        if (rec_stop) begin
          state_d = ST_IDLE;
          if (dur_q != '0) begin
            we      = 1'b1;
            count_d = count_inc;
            full_d  = last_slot;
          end
        end else if (tick) begin
          if (live == cur_q && dur_q != DUR_MAX) begin
            dur_d = dur_q + DUR_W'(1);
          end else begin
            // Saturated or changed input closes the current entry.
            if (dur_q != '0) begin
              we      = 1'b1;
              count_d = count_inc;
              if (last_slot) begin
                full_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end
            cur_d = live;
            dur_d = DUR_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (play_stop) begin
          state_d = ST_IDLE;
        end else if (rd_q == count_q) begin
          // Leave only once the last entry has drained out of the output register.
          if (!vld1_q) begin
            state_d = ST_IDLE;
          end
        end else if (tick) begin
          if (elapsed_q + DUR_W'(1) == rd_dur) begin
            rd_d      = rd_q + CW'(1);
            elapsed_d = '0;
          end else begin
            elapsed_d = elapsed_q + DUR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tick_cnt_d = (tick_clr || tick) ? '0 : tick_cnt_q + TW'(1);
    vld1_d     = (state_q == ST_PLAY) && (rd_q != count_q);

    notes_out_d  = '0;
    octave_out_d = '0;
    if (state_d == ST_PLAY && vld1_q) begin
      notes_out_d  = rdata[NOTES_LSB +: NOTES_W];
      octave_out_d = rdata[OCT_LSB +: OCT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      cur_q        <= '0;
      dur_q        <= '0;
      rd_q         <= '0;
      elapsed_q    <= '0;
      vld1_q       <= 1'b0;
      notes_out_q  <= '0;
      octave_out_q <= '0;
      recording_q  <= 1'b0;
      playing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      count_q      <= count_d;
      full_q       <= full_d;
      cur_q        <= cur_d;
      dur_q        <= dur_d;
      rd_q         <= rd_d;
      elapsed_q    <= elapsed_d;
      vld1_q       <= vld1_d;
      notes_out_q  <= notes_out_d;
      octave_out_q <= octave_out_d;
      recording_q  <= (state_d == ST_REC);
      playing_q    <= (state_d == ST_PLAY);
    end
  end

  assign notes_out  = notes_out_q;
  assign octave_out = octave_out_q;
  assign recording  = recording_q;
  assign playing    = playing_q;
  assign full       = full_q;
  assign count      = count_q;

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder at TICK_DIV=4, DEPTH=8: table of timed vectors
// plus hand-written sequences for saturation, full, and octave replay.
module tb_note_recorder;

  localparam int TICK_DIV = 4;
  localparam int DEPTH    = 8;
  localparam int CW       = $clog2(DEPTH) + 1;

  localparam logic [3:0] C_NONE = 4'b0000;
  localparam logic [3:0] C_RS   = 4'b1000;
  localparam logic [3:0] C_RP   = 4'b0100;
  localparam logic [3:0] C_PS   = 4'b0010;
  localparam logic [3:0] C_PP   = 4'b0001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    notes_in;
  logic [1:0]    octave_in;
  logic          rec_start, rec_stop, play_start, play_stop;
  logic [7:0]    notes_out;
  logic [1:0]    octave_out;
  logic          recording, playing, full;
  logic [CW-1:0] count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          cyc;
    logic        rst_n;
    logic [7:0]  notes;
    logic [1:0]  oct;
    logic [3:0]  cmd;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  note_recorder #(
    .TICK_DIV (TICK_DIV),
    .DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .notes_in   (notes_in),
    .octave_in  (octave_in),
    .rec_start  (rec_start),
    .rec_stop   (rec_stop),
    .play_start (play_start),
    .play_stop  (play_stop),
    .notes_out  (notes_out),
    .octave_out (octave_out),
    .recording  (recording),
    .playing    (playing),
    .full       (full),
    .count      (count)
  );

  function automatic logic [16:0] mk(input logic [7:0] n, input logic [1:0] o,
                                     input logic r, input logic p, input logic f,
                                     input logic [3:0] c);
    return {n, o, r, p, f, c};
  endfunction

  task automatic add(input int cyc, input logic rs, input logic [7:0] n,
                     input logic [3:0] cmd, input logic [16:0] e);
    vec_t v;
    v.cyc   = cyc;
    v.rst_n = rs;
    v.notes = n;
    v.oct   = 2'd0;
    v.cmd   = cmd;
    v.exp   = e;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    logic [17:0] e0, e1;
    logic [7:0]  en;
    logic [1:0]  eo;
    int          ew;

    rst_n = 1'b0; notes_in = '0; octave_in = '0;
    rec_start = 1'b0; rec_stop = 1'b0; play_start = 1'b0; play_stop = 1'b0;

    // Reset, then scenario 1 record (01 x3 ticks, 04 x2 ticks) with play_start ignored in REC
    add(2,  1'b0, 8'h00, C_NONE, mk(8'h00, 2'd0, 0, 0, 0, 4'd0));
    add(1,  1'b1, 8'h00, C_NONE, mk(8'h00, 2'd0, 0, 0, 0, 4'd0));
    add(1,  1'b1, 8'h01, C_RS,   mk(8'h00, 2'd0, 1, 0, 0, 4'd0));
    add(1,  1'b1, 8'h01, C_PS,   mk(8'h00, 2'd0, 1, 0, 0, 4'd0));
    add(11, 1'b1, 8'h01, C_NONE, mk(8'h00, 2'd0, 1, 0, 0, 4'd0));
    add(8,  1'b1, 8'h04, C_NONE, mk(8'h00, 2'd0, 1, 0, 0, 4'd1));
    add(1,  1'b1, 8'h04, C_RP,   mk(8'h00, 2'd0, 0, 0, 0, 4'd2));
    add(2,  1'b1, 8'h00, C_NONE, mk(8'h00, 2'd0, 0, 0, 0, 4'd2));
    // Replay: 01 on cycles 2..13, 04 on cycles 14..21, idle at 22
    add(1,  1'b1, 8'h00, C_PS,   mk(8'h00, 2'd0, 0, 1, 0, 4'd2));
    add(1,  1'b1, 8'h00, C_NONE, mk(8'h00, 2'd0, 0, 1, 0, 4'd2));
    add(1,  1'b1, 8'h00, C_NONE, mk(8'h01, 2'd0, 0, 1, 0, 4'd2));
    add(11, 1'b1, 8'h00, C_NONE, mk(8'h01, 2'd0, 0, 1, 0, 4'd2));
    add(1,  1'b1, 8'h00, C_NONE, mk(8'h04, 2'd0, 0, 1, 0, 4'd2));
    add(7,  1'b1, 8'h00, C_NONE, mk(8'h04, 2'd0, 0, 1, 0, 4'd2));
    add(1,  1'b1, 8'h00, C_NONE, mk(8'h00, 2'd0, 0, 0, 0, 4'd2));
    // Scenario 4: rec_start ignored in PLAY, play_stop mid-entry
    add(1,  1'b1, 8'h00, C_PS,   mk(8'h00, 2'd0, 0, 1, 0, 4'd2));
    add(1,  1'b1, 8'h00, C_RS,   mk(8'h00, 2'd0, 0, 1, 0, 4'd2));
    add(3,  1'b1, 8'h00, C_NONE, mk(8'h01, 2'd0, 0, 1, 0, 4'd2));
    add(1,  1'b1, 8'h00, C_PP,   mk(8'h00, 2'd0, 0, 0, 0, 4'd2));
    add(1,  1'b1, 8'h00, C_NONE, mk(8'h00, 2'd0, 0, 0, 0, 4'd2));
    // Scenario 5: reset during PLAY, then play_start with empty store
    add(1,  1'b1, 8'h00, C_PS,   mk(8'h00, 2'd0, 0, 1, 0, 4'd2));
    add(3,  1'b1, 8'h00, C_NONE, mk(8'h01, 2'd0, 0, 1, 0, 4'd2));
    add(1,  1'b0, 8'h00, C_NONE, mk(8'h00, 2'd0, 0, 0, 0, 4'd0));
    add(1,  1'b1, 8'h00, C_PS,   mk(8'h00, 2'd0, 0, 0, 0, 4'd0));
    add(2,  1'b1, 8'h00, C_NONE, mk(8'h00, 2'd0, 0, 0, 0, 4'd0));
    // Arbitration: REC wins over PLAY; start+stop together is a start
    add(1,  1'b1, 8'h00, C_RS | C_PS, mk(8'h00, 2'd0, 1, 0, 0, 4'd0));
    add(1,  1'b1, 8'h00, C_RP,   mk(8'h00, 2'd0, 0, 0, 0, 4'd0));
    add(1,  1'b1, 8'h00, C_RS | C_RP, mk(8'h00, 2'd0, 1, 0, 0, 4'd0));
    add(1,  1'b1, 8'h00, C_NONE, mk(8'h00, 2'd0, 1, 0, 0, 4'd0));
    add(1,  1'b1, 8'h00, C_RP,   mk(8'h00, 2'd0, 0, 0, 0, 4'd0));

    next();
    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n;
      notes_in = tbl[i].notes;
      octave_in = tbl[i].oct;
      {rec_start, rec_stop, play_start, play_stop} = tbl[i].cmd;
      repeat (tbl[i].cyc) next();
      chk($sformatf("vec%0d", i),
          32'({notes_out, octave_out, recording, playing, full, count}), 32'(tbl[i].exp));
    end
    {rec_start, rec_stop, play_start, play_stop} = C_NONE;

    // Stored scenario 1 entries survived replay, stop and reset
    e0 = {8'h01, 2'd0, 8'd3};
    e1 = {8'h04, 2'd0, 8'd2};
    chk("s1_entry0", 32'(dut.u_mem.mem_q[0]), 32'(e0));
    chk("s1_entry1", 32'(dut.u_mem.mem_q[1]), 32'(e1));

    // Scenario 2: 8'h80 held 300 ticks -> dur 255 then 45
    notes_in = 8'h80; rec_start = 1'b1; next(); rec_start = 1'b0;
    repeat (1100) next();
    chk("s2_mid_count", 32'(count), 32'd1);
    repeat (100) next();
    rec_stop = 1'b1; next(); rec_stop = 1'b0;
    chk("s2_count", 32'(count), 32'd2);
    chk("s2_recording", 32'(recording), 32'd0);
    e0 = {8'h80, 2'd0, 8'd255};
    e1 = {8'h80, 2'd0, 8'd45};
    chk("s2_entry0", 32'(dut.u_mem.mem_q[0]), 32'(e0));
    chk("s2_entry1", 32'(dut.u_mem.mem_q[1]), 32'(e1));

    // Scenario 3: new notes every tick; eighth write (tick 9) fills the store
    notes_in = 8'h00; rec_start = 1'b1; next(); rec_start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      notes_in = 8'(k);
      repeat (TICK_DIV) next();
      ew = (k - 1 > DEPTH) ? DEPTH : k - 1;
      chk($sformatf("s3_count_t%0d", k), 32'(count), 32'(ew));
      chk($sformatf("s3_full_t%0d", k), 32'(full), 32'(k - 1 >= DEPTH));
      chk($sformatf("s3_rec_t%0d", k), 32'(recording), 32'(k - 1 < DEPTH));
    end
    rec_start = 1'b1; next(); rec_start = 1'b0;
    chk("s3_full_cleared", 32'({full, recording, count}), 32'({1'b0, 1'b1, 4'd0}));
    rec_stop = 1'b1; next(); rec_stop = 1'b0;
    chk("s3_empty_stop", 32'({recording, count}), 32'({1'b0, 4'd0}));

    // Scenario 6: octave 0 -> 1 with constant notes creates a new entry and replays
    notes_in = 8'h10; octave_in = 2'd0; rec_start = 1'b1; next(); rec_start = 1'b0;
    repeat (8) next();
    octave_in = 2'd1;
    repeat (8) next();
    rec_stop = 1'b1; next(); rec_stop = 1'b0;
    notes_in = 8'h00; octave_in = 2'd0;
    chk("s6_count", 32'(count), 32'd2);
    e0 = {8'h10, 2'd0, 8'd2};
    e1 = {8'h10, 2'd1, 8'd2};
    chk("s6_entry0", 32'(dut.u_mem.mem_q[0]), 32'(e0));
    chk("s6_entry1", 32'(dut.u_mem.mem_q[1]), 32'(e1));
    play_start = 1'b1; next(); play_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      en = (i >= 2 && i < 18) ? 8'h10 : 8'h00;
      eo = (i >= 10 && i < 18) ? 2'd1 : 2'd0;
      chk($sformatf("s6_play_c%0d", i), 32'({notes_out, octave_out, playing}),
          32'({en, eo, (i < 18) ? 1'b1 : 1'b0}));
      next();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
